// File: rtl/gate_model_bist.sv
// BIST wrapper: LFSR patterns drive one combinational gate model and a MISR compacts its outputs.
// One pattern per SETTLE+1 cycles; the verdict (pass) is registered alongside a one-cycle done pulse.
module gate_model_bist #(
    parameter int              IN_W      = 15,
    parameter int              OUT_W     = 10,
    parameter int              CNT_W     = 16,
    parameter int              SETTLE    = 0,
    parameter logic [IN_W-1:0] LFSR_POLY = 15'h6000,
    parameter logic [OUT_W-1:0] MISR_POLY = 10'h240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] num_patterns_i,
    input  logic [IN_W-1:0]  seed_i,
    input  logic [OUT_W-1:0] golden_i,
    output logic [IN_W-1:0]  dut_in_o,
    input  logic [OUT_W-1:0] dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [OUT_W-1:0] signature_o,
    output logic [CNT_W-1:0] pat_count_o
);

    localparam int             SW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]  SETTLE_V = SW'(SETTLE);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] APPLY = 1'b1;

    logic [0:0]       state_q,  state_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [OUT_W-1:0] sig_q,    sig_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] num_q,    num_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;

    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_pat;

    assign lfsr_next = {dut_in_q[IN_W-2:0], ^(dut_in_q & LFSR_POLY)};
    assign misr_next = {sig_q[OUT_W-2:0], ^(sig_q & MISR_POLY)} ^ dut_out_i;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_pat  = (cnt_inc == num_q);

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        pass_d   = pass_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sig_d = '0;
                    cnt_d = '0;
                    if (num_patterns_i != '0) begin
                        num_d    = num_patterns_i;
                        // An all-zero seed would lock the LFSR at zero forever.
                        dut_in_d = (seed_i == '0) ? IN_W'(1) : seed_i;
                        pass_d   = 1'b0;
                        settle_d = SETTLE_V;
                        state_d  = APPLY;
                    end else begin
                        done_d = 1'b1;
                        pass_d = (golden_i == '0);
                    end
                end
            end
            APPLY: begin
                if (abort_i) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    sig_d = misr_next;
                    cnt_d = cnt_inc;
                    if (last_pat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pass_d  = (misr_next == golden_i);
                    end else begin
                        dut_in_d = lfsr_next;
                        settle_d = SETTLE_V;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dut_in_q <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
            num_q    <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in_o    = dut_in_q;
    assign busy_o      = (state_q == APPLY);
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign signature_o = sig_q;
    assign pat_count_o = cnt_q;

endmodule

// File: doc/gate_model_bist.md
# gate_model_bist

Parametrised built-in self-test wrapper for the combinational gate-library models in the simulator. It drives a gate model's primary inputs with an LFSR pattern sequence and compacts the model's outputs into a MISR signature. It then compares that signature against a golden value. It sits between the simulator test controller and one gate model instance, with one pattern applied per (SETTLE+1) cycles.

## Interface
- IN_W, 15: gate-model input count (LFSR width), ≥2
- OUT_W, 10: gate-model output count (MISR width), ≥2
- CNT_W, 16: pattern-counter width
- SETTLE, 0: extra hold cycles per pattern before capture
- LFSR_POLY, 15'h6000: LFSR feedback tap mask (x^15+x^14+1)
- MISR_POLY, 10'h240: MISR feedback tap mask (x^10+x^7+1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE only)
- abort  in  1  terminate a run without done
- num_patterns  in  CNT_W  pattern count, latched at start
- seed  in  IN_W  LFSR seed, latched at start
- golden  in  OUT_W  expected signature, sampled on the final capture edge
- dut_in  out  IN_W  registered pattern to the gate model
- dut_out  in  OUT_W  gate-model response (combinational from dut_in)
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  signature == golden, valid from done until next start
- signature  out  OUT_W  MISR state
- pat_count  out  CNT_W  patterns captured so far

## Operation
- Reset: dut_in=0, busy=0, done=0, pass=0, signature=0, pat_count=0, state=IDLE, settle counter=0.
- States: IDLE, APPLY.
- LFSR step (Fibonacci): next = {s[IN_W-2:0], ^(s & LFSR_POLY)}.
- MISR step: next = {m[OUT_W-2:0], ^(m & MISR_POLY)} ^ dut_out.
- IDLE, start=1, num_patterns≠0:
  - Latch num_patterns.
  - dut_in ← seed, or 1 if seed==0 (lock-up guard).
  - signature ← 0, pat_count ← 0, pass ← 0, busy ← 1.
  - Settle counter ← SETTLE; go to APPLY.
- IDLE, start=1, num_patterns==0: stay in IDLE, busy stays 0, signature ← 0, pat_count ← 0, done ← 1 next cycle, pass ← (golden==0).
- APPLY, settle counter≠0: decrement the counter; dut_in is held.
- APPLY, settle counter==0 (capture edge):
  - signature ← MISR step, pat_count ← pat_count+1.
  - If pat_count+1 == latched count (last pattern): busy ← 0, done ← 1, pass ← (new signature == golden), go to IDLE; dut_in holds the last pattern.
  - Otherwise: dut_in ← LFSR step, settle counter ← SETTLE.
- done is 1 for exactly one cycle, then clears.
- abort=1 while busy:
  - Next edge: IDLE, busy ← 0, done stays 0, pass ← 0.
  - signature, pat_count and dut_in hold their partial values.
  - abort has priority over a coincident capture.
- abort in IDLE: no effect.
- start while busy: ignored. start and abort both high in IDLE: abort ignored, run starts.
- Changes to num_patterns, seed or golden mid-run have no effect, except golden, which is sampled on the final edge.
- pat_count wraps are impossible: the run ends at the latched count, which is at most 2^CNT_W−1.

## Timing
- Start sampled at edge E0; first pattern is on dut_in after E0.
- Capture k (k=1..N) occurs at edge E0 + k·(SETTLE+1).
- busy is high from after E0 until after E0 + N·(SETTLE+1).
- done and pass are valid in the cycle after edge E0 + N·(SETTLE+1).
- Next start is accepted on the cycle done is high.
- dut_out must settle within SETTLE+1 cycles of a dut_in change.
- Asynchronous reset mid-run forces all reset values immediately; no done is produced.

## Test plan
- Shift sequence: SETTLE=0, seed=0x0001, N=3, dut_out tied to 10'h001 → dut_in sequence 0x0001, 0x0002, 0x0004; signature 0x001, 0x003, 0x007; pat_count=3; done 3 cycles after the start edge; pass=1 with golden=0x007, pass=0 with golden=0x006.
- Seed guard and zero count: seed=0, N=1 → dut_in=0x0001. num_patterns=0, golden=0 → busy never rises, done the next cycle, pass=1, signature=0.
- Settle hold: SETTLE=2, N=4 → each pattern held 3 cycles; done after edge E0+12; busy high for 12 cycles; pat_count steps every 3 cycles.
- Abort: N=100, abort at capture 5 → busy=0 on the next cycle, done never pulses, pass=0, pat_count=5, signature equals the 5-capture value. A subsequent start runs normally.
- Ignored inputs: start pulsed during busy, and num_patterns/seed changed mid-run → identical signature to an undisturbed run.
- Reset: rst_n low mid-run → all outputs 0 asynchronously. After release, IDLE; start works on the first edge.
- Real model: connect the Gatter15 model, seed=0x1ACE, N=1000 → signature matches the reference simulator value; flip one model gate → pass=0.
